// File: rtl/nbitpow_pkg.sv
// +-----------------------------------------------------------------------------+
// | nbitpow_pkg : shared FSM encoding and counter sizing for nbitpow_seq        |
// | Revision    : 1.0                                                           |
// +-----------------------------------------------------------------------------+
`default_nettype none

package nbitpow_pkg;

   localparam logic [0:0] C_ST_IDLE = 1'b0;
   localparam logic [0:0] C_ST_RUN  = 1'b1;

   typedef enum logic [0:0] {
      IDLE = C_ST_IDLE,
      RUN  = C_ST_RUN
   } state_e;

   // Smallest w with 2**w >= n; callers pass EW+1 so the step counter covers 0..EW.
   function automatic int clog2(input int n);
      int w;
      w = 1;
      for (int i = 0; i < 31; i++) begin
         if ((1 << w) < n) w = w + 1;
      end
      return w;
   endfunction

endpackage

`default_nettype wire

// File: rtl/nbitmul.sv
// +-----------------------------------------------------------------------------+
// | nbitmul  : combinational WIDTH x WIDTH -> 2*WIDTH unsigned multiplier        |
// | Revision : 1.0                                                               |
// +-----------------------------------------------------------------------------+
`default_nettype none

module nbitmul #(
   parameter int WIDTH = 6
) (
   input  logic [WIDTH-1:0]   a_i,
   input  logic [WIDTH-1:0]   b_i,
   output logic [2*WIDTH-1:0] p_o
);

   assign p_o = {{WIDTH{1'b0}}, a_i} * {{WIDTH{1'b0}}, b_i};

endmodule

`default_nettype wire

// File: rtl/nbitpow_seq.sv
// +-----------------------------------------------------------------------------+
// | nbitpow_seq : sequential ain^bin by right-to-left square-and-multiply,       |
// |               one exponent bit per clock, exact overflow flag.               |
// |               Option macro NBITPOW_SATURATE_EN: overflowed results read as   |
// |               all ones instead of the modular value.                         |
// | Revision    : 1.0                                                            |
// +-----------------------------------------------------------------------------+
`default_nettype none

module nbitpow_seq
   import nbitpow_pkg::*;
#(
   parameter int WIDTH = 6,
   parameter int EW    = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] ain,
   input  logic [EW-1:0]    bin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] pow,
   output logic             overflow
);

   localparam int CW = clog2(EW + 1);

   state_e             state_q;
   logic [WIDTH-1:0]   base_q;
   logic [WIDTH-1:0]   acc_q;
   logic [EW-1:0]      exp_q;
   logic [CW-1:0]      cnt_q;
   logic               base_ovf_q;
   logic               acc_ovf_q;
   logic               busy_q;
   logic               done_q;
   logic [WIDTH-1:0]   pow_q;
   logic               ovf_q;

   logic [2*WIDTH-1:0] w_sq;
   logic [2*WIDTH-1:0] w_mul;
   logic [WIDTH-1:0]   base_d;
   logic               base_ovf_d;
   logic [WIDTH-1:0]   acc_d;
   logic               acc_ovf_d;
   logic [WIDTH-1:0]   pow_d;
   logic               w_last;

   nbitmul #(.WIDTH(WIDTH)) u_sq (
      .a_i (base_q),
      .b_i (base_q),
      .p_o (w_sq)
   );

   nbitmul #(.WIDTH(WIDTH)) u_mul (
      .a_i (acc_q),
      .b_i (base_q),
      .p_o (w_mul)
   );

   assign w_last = (cnt_q == CW'(EW - 1));

   always_comb begin
      base_d     = w_sq[WIDTH-1:0];
      base_ovf_d = base_ovf_q | (|w_sq[2*WIDTH-1:WIDTH]);
      acc_d      = acc_q;
      acc_ovf_d  = acc_ovf_q;
      if (exp_q[0]) begin
         acc_d     = w_mul[WIDTH-1:0];
         // An overflowed base is always >= 2, so multiplying it in overflows too.
         acc_ovf_d = acc_ovf_q | base_ovf_q | (|w_mul[2*WIDTH-1:WIDTH]);
      end
      pow_d = acc_d;
`ifdef NBITPOW_SATURATE_EN
      if (acc_ovf_d) pow_d = '1;
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         base_q     <= '0;
         acc_q      <= '0;
         exp_q      <= '0;
         cnt_q      <= '0;
         base_ovf_q <= 1'b0;
         acc_ovf_q  <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         pow_q      <= '0;
         ovf_q      <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  state_q    <= RUN;
                  busy_q     <= 1'b1;
                  base_q     <= ain;
                  exp_q      <= bin;
                  acc_q      <= WIDTH'(1);
                  base_ovf_q <= 1'b0;
                  acc_ovf_q  <= 1'b0;
                  cnt_q      <= '0;
               end
            end
            RUN: begin
               base_q     <= base_d;
               base_ovf_q <= base_ovf_d;
               acc_q      <= acc_d;
               acc_ovf_q  <= acc_ovf_d;
               exp_q      <= exp_q >> 1;
               cnt_q      <= cnt_q + CW'(1);
               if (w_last) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  pow_q   <= pow_d;
                  ovf_q   <= acc_ovf_d;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign pow      = pow_q;
   assign overflow = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_nbitpow_seq.sv
// +-----------------------------------------------------------------------------+
// | tb_nbitpow_seq : self-checking bench for nbitpow_seq at 6/6 and 12/8         |
// | Revision       : 1.0                                                         |
// +-----------------------------------------------------------------------------+
`default_nettype none

module tb_nbitpow_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        start, start12;
   logic [5:0]  ain, bin;
   logic [11:0] ain12;
   logic [7:0]  bin12;
   logic        busy, done, overflow;
   logic [5:0]  pow;
   logic        busy12, done12, overflow12;
   logic [11:0] pow12;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   nbitpow_seq #(.WIDTH(6), .EW(6)) dut (
      .clk(clk), .rst(rst), .start(start), .ain(ain), .bin(bin),
      .busy(busy), .done(done), .pow(pow), .overflow(overflow)
   );

   nbitpow_seq #(.WIDTH(12), .EW(8)) dut12 (
      .clk(clk), .rst(rst), .start(start12), .ain(ain12), .bin(bin12),
      .busy(busy12), .done(done12), .pow(pow12), .overflow(overflow12)
   );

   // Reference: repeated multiplication; true value capped at 2^w to detect overflow.
   task automatic model(input int w, input longint a, input longint b,
                        output longint p, output logic o);
      longint m, r, t;
      m = longint'(1) << w;
      r = 1;
      t = 1;
      for (longint i = 0; i < b; i++) begin
         r = (r * a) % m;
         t = t * a;
         if (t >= m) t = m;
      end
      o = (t >= m);
      p = r;
`ifdef NBITPOW_SATURATE_EN
      if (o) p = m - 1;
`endif
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Launch one operation, wait for done (bounded), check latency and result.
   task automatic run_op(input bit big, input int a, input int b, input string tag);
      int     t_acc, n, lat;
      longint ep;
      logic   eo;
      @(negedge clk);
      if (big) begin start12 = 1'b1; ain12 = 12'(a); bin12 = 8'(b); end
      else     begin start   = 1'b1; ain   = 6'(a);  bin   = 6'(b);  end
      @(posedge clk); #1;
      start = 1'b0; start12 = 1'b0;
      t_acc = cyc;
      chk({tag, "/busy"}, big ? busy12 : busy, 64'd1);
      n = 0;
      while (!(big ? done12 : done) && n < 40) begin
         @(posedge clk); #1; n++;
      end
      lat = cyc - t_acc;
      chk({tag, "/latency"}, 64'(lat), big ? 64'd8 : 64'd6);
      model(big ? 12 : 6, longint'(a), longint'(b), ep, eo);
      chk({tag, "/pow"}, big ? 64'(pow12) : 64'(pow), 64'(ep));
      chk({tag, "/ovf"}, big ? overflow12 : overflow, 64'(eo));
      chk({tag, "/idle"}, big ? busy12 : busy, 64'd0);
   endtask

   initial begin
      int     t0, t1, n;
      logic   seen;
      rst = 1'b1; start = 1'b0; start12 = 1'b0;
      ain = '0; bin = '0; ain12 = '0; bin12 = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset/busy", busy, 64'd0);
      chk("reset/done", done, 64'd0);
      chk("reset/pow", pow, 64'd0);
      chk("reset/ovf", overflow, 64'd0);
      chk("reset/pow12", pow12, 64'd0);

      // Reset wins over a simultaneous start.
      @(negedge clk);
      start = 1'b1; ain = 6'd3; bin = 6'd3;
      @(posedge clk); #1;
      rst = 1'b0; start = 1'b0;
      chk("rst_vs_start/busy", busy, 64'd0);
      @(posedge clk); #1;
      chk("rst_vs_start/busy2", busy, 64'd0);

      run_op(1'b0, 3, 3, "3^3");
      chk("3^3/const", pow, 64'd27);
      run_op(1'b0, 2, 6, "2^6");
      run_op(1'b0, 7, 2, "7^2");
      run_op(1'b0, 8, 2, "8^2");
      run_op(1'b0, 0, 0, "0^0");
      chk("0^0/const", pow, 64'd1);
      run_op(1'b0, 1, 63, "1^63");
      run_op(1'b0, 63, 1, "63^1");
      run_op(1'b0, 0, 5, "0^5");

      // Starts while busy are ignored; start in the done cycle is accepted.
      @(negedge clk);
      start = 1'b1; ain = 6'd3; bin = 6'd3;
      @(posedge clk); #1;
      start = 1'b0; t0 = cyc;
      @(posedge clk); #1;
      start = 1'b1; ain = 6'd2; bin = 6'd6;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      start = 1'b1; ain = 6'd8; bin = 6'd2;
      @(posedge clk); #1;
      start = 1'b0;
      n = 0;
      while (!done && n < 20) begin @(posedge clk); #1; n++; end
      chk("hs/latency", 64'(cyc - t0), 64'd6);
      chk("hs/pow", pow, 64'd27);
      chk("hs/ovf", overflow, 64'd0);
      t1 = cyc;
      start = 1'b1; ain = 6'd7; bin = 6'd2;
      @(posedge clk); #1;
      start = 1'b0;
      chk("hs/done_pulse", done, 64'd0);
      chk("hs/b2b_busy", busy, 64'd1);
      n = 0;
      while (!done && n < 20) begin @(posedge clk); #1; n++; end
      chk("hs/b2b_gap", 64'(cyc - t1), 64'd7);
      chk("hs/b2b_pow", pow, 64'd49);

      // Reset mid-operation aborts with no done pulse.
      @(negedge clk);
      start = 1'b1; ain = 6'd5; bin = 6'd3;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("abort/busy", busy, 64'd0);
      chk("abort/done", done, 64'd0);
      chk("abort/pow", pow, 64'd0);
      chk("abort/ovf", overflow, 64'd0);
      seen = 1'b0;
      repeat (10) begin @(posedge clk); #1; if (done) seen = 1'b1; end
      chk("abort/no_done", seen, 64'd0);
      run_op(1'b0, 5, 3, "after_abort");

      for (int a = 0; a < 64; a++)
         for (int b = 0; b < 64; b++)
            run_op(1'b0, a, b, "sweep6");

      for (int i = 0; i < 300; i++)
         run_op(1'b1, int'($urandom_range(4095)), int'($urandom_range(255)), "rand12");
      run_op(1'b1, 4095, 255, "rand12/max");
      run_op(1'b1, 2, 11, "rand12/2^11");
      run_op(1'b1, 2, 12, "rand12/2^12");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/nbitpow_seq.md
# nbitpow_seq

Parametrised, sequential successor to the combinational six-bit power unit. It computes `ain^bin` by right-to-left square-and-multiply, processing one exponent bit per clock behind a start/busy/done handshake. It reports the result modulo 2^WIDTH and flags overflow exactly. It sits in the calculator datapath wherever wider operands make a single-cycle power tree impractical.

## Interface
- `WIDTH`, default 6: base and result width in bits.
- `EW`, default 6: exponent width in bits; sets latency. Must be ≥1.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `start` in 1: request; sampled only while idle.
- `ain` in WIDTH: base, unsigned; captured on accepted start.
- `bin` in EW: exponent, unsigned; captured on accepted start.
- `busy` out 1: high while an operation is in progress.
- `done` out 1: one-cycle pulse; `pow`/`overflow` are valid from this cycle on.
- `pow` out WIDTH: result; holds until the next completion.
- `overflow` out 1: true result ≥ 2^WIDTH; holds with `pow`.

## Operation
- FSM states:
  - IDLE to RUN on `start`. Load base=`ain`, exp=`bin`, acc=1. Clear acc_ovf, base_ovf and bit counter.
  - RUN: one step per cycle for exactly EW cycles, then back to IDLE.
- RUN step, for the current LSB of exp:
  - If the bit is 1: acc ← low WIDTH bits of acc×base. acc_ovf ← acc_ovf | base_ovf | (high half of product ≠ 0).
  - Always: base ← low WIDTH bits of base×base. base_ovf ← base_ovf | (high half of square ≠ 0).
  - Then shift exp right and increment the counter.
- Truncated arithmetic is exact mod 2^WIDTH, so `pow` = a^b mod 2^WIDTH in every case.
- Overflow is exact. A set bit meeting an overflowed base overflows, since base ≥ 2 whenever base_ovf is set. Base 0 and base 1 never set base_ovf.
- Defined values:
  - 0^0 = 1.
  - b=0 gives 1 with no overflow.
  - 0^b = 0 for b>0.
- `start` while busy is ignored and operands are not re-sampled.
- Reset values: state IDLE, `busy`=0, `done`=0, `pow`=0, `overflow`=0, internal registers cleared.
- Reset mid-operation aborts with no `done` pulse. `pow`/`overflow` return to 0.

## Timing
- Accepting edge t0: `busy` rises after t0.
- Steps occur at edges t0+1 … t0+EW.
- At edge t0+EW: `pow`/`overflow` are registered, `done`=1, `busy`=0.
- `done` drops at t0+EW+1. Latency is fixed at EW cycles from accept to `done`, independent of operand values.
- Back-to-back: `start` asserted during the `done` cycle is accepted, giving one result every EW+1 cycles.
- `start` and `rst` in the same cycle: reset wins.

## Configuration
- `NBITPOW_SATURATE_EN`:
  - Defined: on completion with overflow=1, `pow` is forced to all ones (2^WIDTH−1).
  - Undefined: `pow` is the modular result.
- `overflow` behaviour is identical in both builds.

## Structure
- Shared package `nbitpow_pkg` holds the FSM state encoding (IDLE, RUN) as localparams and the counter width function clog2(EW+1).
- Sub-module `nbitmul`: combinational WIDTH×WIDTH→2·WIDTH unsigned multiplier. Instantiated twice, once for square and once for accumulate.
- The top level holds the FSM, counter, sticky flags and output registers.

## Test plan
- WIDTH=6, EW=6: start with a=3, b=3 → `done` exactly 6 cycles after accept, `pow`=27, `overflow`=0.
- a=2, b=6 → `pow`=0, `overflow`=1 (63 with NBITPOW_SATURATE_EN). a=7, b=2 → 49, no overflow. a=8, b=2 → 0, overflow.
- Boundaries:
  - a=0, b=0 → 1, no overflow.
  - a=1, b=63 → 1, no overflow.
  - a=63, b=1 → 63, no overflow.
  - a=0, b=5 → 0, no overflow.
- Handshake: pulse `start` with new operands at accept+2 and +4 → ignored. Next `start` during the `done` cycle → accepted, second `done` 7 cycles after the first.
- Reset at accept+3 → `busy`=0, no `done`, `pow`=0, `overflow`=0 next cycle. A subsequent operation completes correctly.
- Exhaustive 64×64 sweep, plus a random sweep at WIDTH=12/EW=8 → `pow` and `overflow` match a 64-bit behavioural model in both macro builds.
